// File: rtl/rob_commit.sv
// rob_commit: in-order retire stage for the ROB head, covering ALU writeback, store handoff and exception flush
module rob_commit #(
  parameter int WORD_SIZE = 32,
  parameter int REG_ADDR = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter logic [WORD_SIZE-1:0] EXC_VECTOR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 head_valid,
  input  logic                 head_ready,
  input  logic                 head_exception,
  input  logic                 head_is_store,
  input  logic [REG_ADDR-1:0]  head_rd,
  input  logic [WORD_SIZE-1:0] head_value,
  input  logic [WORD_SIZE-1:0] head_addr,
  input  logic [WORD_SIZE-1:0] head_pc,
  output logic                 pop,
  output logic                 rf_we,
  output logic [REG_ADDR-1:0]  rf_waddr,
  output logic [WORD_SIZE-1:0] rf_wdata,
  output logic                 st_valid,
  output logic [WORD_SIZE-1:0] st_addr,
  output logic [WORD_SIZE-1:0] st_data,
  input  logic                 st_ack,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic [WORD_SIZE-1:0] epc,
  output logic [31:0]          retired_count
);
  localparam int CW = $clog2(FLUSH_CYCLES) + 1;
  typedef enum logic [1:0] {RUN, STORE_WAIT, FLUSH} state_t;
  state_t state;
  logic [CW-1:0] flush_cnt;
  logic commit, alu;
  // Strobes are masked during rst so nothing retires while the block is being cleared
  always_comb begin
    commit = !rst && state == RUN && head_valid && head_ready;
    alu = commit && !head_exception && !head_is_store;
    pop = alu || (!rst && state == STORE_WAIT && st_ack);
    rf_we = alu && head_rd != '0;
    rf_waddr = alu ? head_rd : '0;
    rf_wdata = alu ? head_value : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      st_valid <= 1'b0;
      st_addr <= '0;
      st_data <= '0;
      flush <= 1'b0;
      flush_cnt <= '0;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      epc <= '0;
      retired_count <= '0;
    end else begin
      retired_count <= retired_count + 32'(pop);
      redirect_valid <= 1'b0;
      case (state)
        RUN:
          if (commit && head_exception) begin
            epc <= head_pc;
            redirect_valid <= 1'b1;
            redirect_pc <= EXC_VECTOR;
            flush <= 1'b1;
            flush_cnt <= CW'(FLUSH_CYCLES - 1);
            state <= FLUSH;
          end else if (commit && head_is_store) begin
            st_addr <= head_addr;
            st_data <= head_value;
            st_valid <= 1'b1;
            state <= STORE_WAIT;
          end
        STORE_WAIT:
          if (st_ack) begin
            st_valid <= 1'b0;
            state <= RUN;
          end
        FLUSH:
          if (flush_cnt == '0) begin
            flush <= 1'b0;
            state <= RUN;
          end else flush_cnt <= flush_cnt - 1'b1;
        default: state <= RUN;
      endcase
    end
  end
endmodule
